// File: rtl/myproject_mul_pkg.sv
// Shared definitions for the pipelined multi-lane multiplier.
// The optional round/saturate stage is enabled by defining MYPROJECT_MUL_SAT_EN.
package myproject_mul_pkg;

   // Widest intermediate the post-processing path works in; product width and dout_WIDTH stay below it
   localparam int unsigned MAXW = 64;

   // Packed lane result as produced by the clamp helper
   typedef struct packed {
      logic                   ovf;
      logic signed [MAXW-1:0] data;
   } lane_res_t;

   // Full-precision product width: one extra bit covers the unsigned x signed corner
   function automatic int unsigned pw_of(input int unsigned w0, input int unsigned w1);
      return w0 + w1 + 1;
   endfunction

   // Clamp a signed value into a width-bit two's complement range and flag the clamp
   function automatic lane_res_t sat_trunc(input logic signed [MAXW-1:0] value,
                                           input int unsigned            width);
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      lane_res_t              res;
      hi       = (MAXW'(1) << (width - 32'd1)) - MAXW'(1);
      lo       = ~hi;
      res.ovf  = 1'b0;
      res.data = value;
      if (value > hi) begin
         res.ovf  = 1'b1;
         res.data = hi;
      end else if (value < lo) begin
         res.ovf  = 1'b1;
         res.data = lo;
      end
      return res;
   endfunction

endpackage

// File: rtl/myproject_mul_lane.sv
// One multiplier lane: operand extension, full product, product stages and the
// shift / round / saturate post-processing feeding the output register.
// MYPROJECT_MUL_SAT_EN selects round-half-up plus clamp; otherwise truncate and wrap.
module myproject_mul_lane
   import myproject_mul_pkg::*;
#(
   parameter int unsigned din0_WIDTH  = 16,
   parameter int unsigned din1_WIDTH  = 10,
   parameter int unsigned dout_WIDTH  = 26,
   parameter int unsigned NUM_STAGE   = 2,
   parameter int unsigned SHIFT       = 0,
   parameter int unsigned DIN0_SIGNED = 1,
   parameter int unsigned DIN1_SIGNED = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  i_vld_last,
   input  logic [din0_WIDTH-1:0] i_din0,
   input  logic [din1_WIDTH-1:0] i_din1,
   output logic [dout_WIDTH-1:0] o_dout,
   output logic                  o_ovf
);

   localparam int unsigned PW = pw_of(din0_WIDTH, din1_WIDTH);

   logic signed [PW-1:0]   w_op0;
   logic signed [PW-1:0]   w_op1;
   logic signed [PW-1:0]   w_prod;
   logic signed [PW-1:0]   w_pp;
   logic signed [MAXW-1:0] w_ext;
   logic signed [MAXW-1:0] w_shf;
   logic [dout_WIDTH-1:0]  w_res;
   logic                   w_ovf;
   logic                   w_unused;
   logic [dout_WIDTH-1:0]  r_dout;
   logic                   r_ovf;

`ifdef MYPROJECT_MUL_SAT_EN
   localparam logic signed [MAXW-1:0] RND = (SHIFT == 0) ? '0 : (MAXW'(1) << (SHIFT - 32'd1));
   lane_res_t w_sat;
`endif

   // Extend each operand per its signedness and form the exact product
   always_comb begin
      w_op0  = {{(PW - din0_WIDTH){(DIN0_SIGNED != 0) & i_din0[din0_WIDTH-1]}}, i_din0};
      w_op1  = {{(PW - din1_WIDTH){(DIN1_SIGNED != 0) & i_din1[din1_WIDTH-1]}}, i_din1};
      w_prod = w_op0 * w_op1;
   end

   generate
      if (NUM_STAGE == 1) begin : g_no_chain
         assign w_pp = w_prod;
      end else begin : g_chain
         logic signed [PW-1:0] r_prod [NUM_STAGE-1];

         // Product stages ahead of the output register; data loads even for bubbles
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < int'(NUM_STAGE) - 1; i++) r_prod[i] <= '0;
            end else if (ce) begin
               r_prod[0] <= w_prod;
               for (int i = 1; i < int'(NUM_STAGE) - 1; i++) r_prod[i] <= r_prod[i-1];
            end
         end

         assign w_pp = r_prod[NUM_STAGE-2];
      end
   endgenerate

   // Arithmetic post-shift, then clamp or wrap into the lane result width
   always_comb begin
      w_ext = {{(MAXW - PW){w_pp[PW-1]}}, w_pp};
`ifdef MYPROJECT_MUL_SAT_EN
      w_shf    = (w_ext + RND) >>> SHIFT;
      w_sat    = sat_trunc(w_shf, dout_WIDTH);
      w_res    = w_sat.data[dout_WIDTH-1:0];
      w_ovf    = w_sat.ovf;
      w_unused = ^w_sat.data[MAXW-1:dout_WIDTH];
`else
      w_shf    = w_ext >>> SHIFT;
      w_res    = w_shf[dout_WIDTH-1:0];
      w_ovf    = 1'b0;
      w_unused = ^w_shf[MAXW-1:dout_WIDTH];
`endif
   end

   // Output register; the overflow flag only survives alongside a valid result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dout <= '0;
         r_ovf  <= 1'b0;
      end else if (ce) begin
         r_dout <= w_res;
         r_ovf  <= w_ovf & i_vld_last;
      end
   end

   assign o_dout = r_dout;
   assign o_ovf  = r_ovf;

endmodule

// File: rtl/myproject_mul_pipe.sv
// Multi-lane pipelined fixed-point multiplier: shared valid chain plus one
// datapath lane per channel, all advancing together on ce.
// Define MYPROJECT_MUL_SAT_EN for round-half-up and saturation with per-lane ovf.
module myproject_mul_pipe
   import myproject_mul_pkg::*;
#(
   parameter int unsigned CHANNELS    = 1,
   parameter int unsigned din0_WIDTH  = 16,
   parameter int unsigned din1_WIDTH  = 10,
   parameter int unsigned dout_WIDTH  = 26,
   parameter int unsigned NUM_STAGE   = 2,
   parameter int unsigned SHIFT       = 0,
   parameter int unsigned DIN0_SIGNED = 1,
   parameter int unsigned DIN1_SIGNED = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ce,
   input  logic                           in_valid,
   input  logic [CHANNELS*din0_WIDTH-1:0] din0,
   input  logic [CHANNELS*din1_WIDTH-1:0] din1,
   output logic                           out_valid,
   output logic [CHANNELS*dout_WIDTH-1:0] dout,
   output logic [CHANNELS-1:0]            ovf
);

   logic [NUM_STAGE-1:0] r_vld;
   logic                 w_vld_last;

   // Valid tracking shared by all lanes; bubbles travel as zeros
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld <= '0;
      end else if (ce) begin
         r_vld[0] <= in_valid;
         for (int i = 1; i < int'(NUM_STAGE); i++) r_vld[i] <= r_vld[i-1];
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_vld_direct
         assign w_vld_last = in_valid;
      end else begin : g_vld_chain
         assign w_vld_last = r_vld[NUM_STAGE-2];
      end
   endgenerate

   assign out_valid = r_vld[NUM_STAGE-1];

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
         myproject_mul_lane #(
            .din0_WIDTH (din0_WIDTH),
            .din1_WIDTH (din1_WIDTH),
            .dout_WIDTH (dout_WIDTH),
            .NUM_STAGE  (NUM_STAGE),
            .SHIFT      (SHIFT),
            .DIN0_SIGNED(DIN0_SIGNED),
            .DIN1_SIGNED(DIN1_SIGNED)
         ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .i_vld_last(w_vld_last),
            .i_din0    (din0[k*din0_WIDTH +: din0_WIDTH]),
            .i_din1    (din1[k*din1_WIDTH +: din1_WIDTH]),
            .o_dout    (dout[k*dout_WIDTH +: dout_WIDTH]),
            .o_ovf     (ovf[k])
         );
      end
   endgenerate

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Bench for myproject_mul_pipe: four configurations driven from shared lane operands,
// each checked against an arithmetic reference with a per-ce-edge input history.
// Expectations follow MYPROJECT_MUL_SAT_EN when the build defines it.
module tb_myproject_mul_pipe;

   // Per-instance configuration: 0 defaults, 1 four lanes / 3 stages / narrow,
   // 2 single stage with rounding shift, 3 unsigned din0
   localparam int NS [4] = '{2, 3, 1, 2};
   localparam int CHN[4] = '{1, 4, 2, 1};
   localparam int SH [4] = '{0, 4, 2, 0};
   localparam int WO [4] = '{26, 16, 26, 26};
   localparam int S0 [4] = '{1, 1, 1, 0};

   localparam bit STALL_CE[14] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
   localparam bit STALL_V [14] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

`ifdef MYPROJECT_MUL_SAT_EN
   localparam logic [63:0] RND_EXP = 64'h3FF_FFFE;
   localparam logic [63:0] SAT_EXP = 64'h7FFF;
   localparam logic [63:0] SAT_OVF = 64'd1;
`else
   localparam logic [63:0] RND_EXP = 64'h3FF_FFFD;
   localparam logic [63:0] SAT_EXP = 64'hF7E0;
   localparam logic [63:0] SAT_OVF = 64'd0;
`endif

   typedef struct packed {
      logic        v;
      logic [63:0] a;
      logic [39:0] b;
   } rec_t;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic [63:0] va;
   logic [39:0] vb;

   logic        ov0, ov1, ov2, ov3;
   logic [25:0] do0;
   logic [63:0] do1;
   logic [51:0] do2;
   logic [25:0] do3;
   logic [0:0]  of0;
   logic [3:0]  of1;
   logic [1:0]  of2;
   logic [0:0]  of3;

   int   errors = 0;
   int   checks = 0;
   rec_t hist[$];

   myproject_mul_pipe u_dut0 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
      .din0(va[15:0]), .din1(vb[9:0]), .out_valid(ov0), .dout(do0), .ovf(of0));

   myproject_mul_pipe #(.CHANNELS(4), .dout_WIDTH(16), .NUM_STAGE(3), .SHIFT(4)) u_dut1 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
      .din0(va), .din1(vb), .out_valid(ov1), .dout(do1), .ovf(of1));

   myproject_mul_pipe #(.CHANNELS(2), .NUM_STAGE(1), .SHIFT(2)) u_dut2 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
      .din0(va[31:0]), .din1(vb[19:0]), .out_valid(ov2), .dout(do2), .ovf(of2));

   myproject_mul_pipe #(.DIN0_SIGNED(0)) u_dut3 (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
      .din0(va[15:0]), .din1(vb[9:0]), .out_valid(ov3), .dout(do3), .ovf(of3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs accepted on each advancing edge; reset discards everything in flight
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist.delete();
      end else if (ce) begin
         hist.push_back({in_valid, va, vb});
         if (hist.size() > 4) void'(hist.pop_front());
      end
   end

   // Reference: exact product, optional round, floor shift, then clamp or wrap
   function automatic logic [64:0] model(input int d, input logic [15:0] a, input logic [9:0] b);
      longint x, y, p;
      logic   of;
`ifdef MYPROJECT_MUL_SAT_EN
      longint hi;
`endif
      of = 1'b0;
      x  = (S0[d] != 0) ? longint'($signed(a)) : longint'(a);
      y  = longint'($signed(b));
      p  = x * y;
`ifdef MYPROJECT_MUL_SAT_EN
      if (SH[d] > 0) p = p + (longint'(1) <<< (SH[d] - 1));
      p  = p >>> SH[d];
      hi = (longint'(1) <<< (WO[d] - 1)) - 1;
      if (p > hi) begin
         p = hi; of = 1'b1;
      end else if (p < -hi - 1) begin
         p = -hi - 1; of = 1'b1;
      end
`else
      p = p >>> SH[d];
`endif
      return {of, 64'(p) & ((64'd1 << WO[d]) - 64'd1)};
   endfunction

   function automatic logic get_vld(input int d);
      case (d)
         0:       return ov0;
         1:       return ov1;
         2:       return ov2;
         default: return ov3;
      endcase
   endfunction

   function automatic logic [63:0] get_dout(input int d, input int l);
      case (d)
         0:       return 64'(do0);
         1:       return 64'(do1[l*16 +: 16]);
         2:       return 64'(do2[l*26 +: 26]);
         default: return 64'(do3);
      endcase
   endfunction

   function automatic logic get_ovf(input int d, input int l);
      case (d)
         0:       return of0[0];
         1:       return of1[l];
         2:       return of2[l];
         default: return of3[0];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every instance against the reference built from the input history
   task automatic check_all();
      for (int d = 0; d < 4; d++) begin
         int          idx;
         logic        ev;
         rec_t        r;
         logic [64:0] m;
         idx = hist.size() - NS[d];
         ev  = 1'b0;
         r   = '0;
         if (idx >= 0) begin
            r  = hist[idx];
            ev = r.v;
         end
         chk($sformatf("out_valid d%0d", d), 64'(get_vld(d)), 64'(ev));
         for (int l = 0; l < CHN[d]; l++) begin
            if (ev) begin
               m = model(d, r.a[l*16 +: 16], r.b[l*10 +: 10]);
               chk($sformatf("dout d%0d l%0d", d, l), get_dout(d, l), m[63:0]);
               chk($sformatf("ovf d%0d l%0d", d, l), 64'(get_ovf(d, l)), 64'(m[64]));
            end else begin
               chk($sformatf("ovf_idle d%0d l%0d", d, l), 64'(get_ovf(d, l)), 64'd0);
            end
         end
      end
   endtask

   task automatic check_reset(input string tag);
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("%s out_valid d%0d", tag, d), 64'(get_vld(d)), 64'd0);
         for (int l = 0; l < CHN[d]; l++) begin
            chk($sformatf("%s dout d%0d l%0d", tag, d, l), get_dout(d, l), 64'd0);
            chk($sformatf("%s ovf d%0d l%0d", tag, d, l), 64'(get_ovf(d, l)), 64'd0);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic rand_ops();
      va = {$urandom, $urandom};
      vb = 40'({$urandom, $urandom});
   endtask

   initial begin
      reset    = 1'b0;
      ce       = 1'b0;
      in_valid = 1'b0;
      va       = '0;
      vb       = '0;
      repeat (2) @(negedge clk);
      check_reset("por");
      reset = 1'b1;

      // Directed vectors: lane0 basic, lane1 rounding, lane2 saturation
      ce       = 1'b1;
      in_valid = 1'b1;
      va       = {16'h0000, 16'h7FFF, 16'hFFFD, 16'h8000};
      vb       = {10'd0, 10'd511, 10'd3, 10'h200};
      step();
      chk("latency1 d0", 64'(ov0), 64'd0);
      chk("round d2", get_dout(2, 1), RND_EXP);
      va[15:0] = 16'hFFFF;
      vb[9:0]  = 10'd2;
      step();
      chk("latency2 d0", 64'(ov0), 64'd1);
      chk("basic d0", get_dout(0, 0), 64'd16777216);
      in_valid = 1'b0;
      step();
      chk("unsigned d3", get_dout(3, 0), 64'd131070);
      chk("sat d1", get_dout(1, 2), SAT_EXP);
      chk("sat_ovf d1", 64'(get_ovf(1, 2)), SAT_OVF);

      // Stream with a bubble and a four-cycle stall
      for (int i = 0; i < 14; i++) begin
         ce       = STALL_CE[i];
         in_valid = STALL_V[i];
         rand_ops();
         step();
      end

      // Random ce / valid / operands
      for (int i = 0; i < 300; i++) begin
         ce       = ($urandom_range(0, 3) != 0);
         in_valid = $urandom_range(0, 1) != 0;
         rand_ops();
         step();
      end

      // Reset with results in flight
      ce       = 1'b1;
      in_valid = 1'b1;
      rand_ops();
      step();
      rand_ops();
      step();
      in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      #1 check_reset("async");
      @(negedge clk);
      check_all();
      step();
      reset = 1'b1;
      repeat (4) step();
      in_valid = 1'b1;
      rand_ops();
      step();
      in_valid = 1'b0;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
